// File: rtl/fft_out_reorder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fft_out_reorder: bit-reversed 16-lane FFT beats -> natural-order frames   |
// | via a two-bank ping-pong register buffer.  Revision: 1.0                  |
// +--------------------------------------------------------------------------+
module fft_out_reorder #(
  parameter int WIDTH  = 11,
  parameter int LANES  = 16,
  parameter int NPOINT = 512
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     din_valid,
  input  logic [WIDTH*LANES-1:0]   din_re,
  input  logic [WIDTH*LANES-1:0]   din_im,
  input  logic                     dout_ready,
  output logic                     dout_valid,
  output logic [WIDTH*LANES-1:0]   dout_re,
  output logic [WIDTH*LANES-1:0]   dout_im,
  output logic [4:0]               dout_beat,
  output logic                     dout_last,
  output logic                     ovf_err
);

  localparam int BEATS = NPOINT / LANES;
  localparam int LW    = $clog2(LANES);
  localparam int BW    = $clog2(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_DRAIN = 1'b1} state_t;

  function automatic logic [LW-1:0] rev_lane(input logic [LW-1:0] x);
    logic [LW-1:0] r;
    for (int i = 0; i < LW; i++) r[i] = x[LW-1-i];
    return r;
  endfunction

  function automatic logic [BW-1:0] rev_beat(input logic [BW-1:0] x);
    logic [BW-1:0] r;
    for (int i = 0; i < BW; i++) r[i] = x[BW-1-i];
    return r;
  endfunction

  logic [WIDTH-1:0] r_mem_re [2][NPOINT];
  logic [WIDTH-1:0] r_mem_im [2][NPOINT];

  logic [BW-1:0] r_wcnt;
  logic          r_wbank;
  logic          r_drop;
  logic          r_ovf;
  logic [1:0]    r_full;
  state_t        r_state;
  logic          r_rbank;
  logic [BW-1:0] r_beat;

  logic   w_free;
  logic   w_wbank_busy;
  logic   w_wr_en;
  logic   w_mark;
  logic   w_accept;
  logic [1:0] w_full_nxt;
  state_t w_state_nxt;

  assign w_accept = dout_valid && dout_ready;
  assign w_free   = w_accept && (r_beat == LAST_BEAT);
  // A bank released on this edge is already free for a frame starting now.
  assign w_wbank_busy = r_full[r_wbank] && !(w_free && (r_rbank == r_wbank));
  assign w_wr_en = din_valid && ((r_wcnt == '0) ? !w_wbank_busy : !r_drop);
  assign w_mark  = w_wr_en && (r_wcnt == LAST_BEAT);

  always_comb begin
    w_full_nxt = r_full;
    if (w_free) w_full_nxt[r_rbank] = 1'b0;
    if (w_mark) w_full_nxt[r_wbank] = 1'b1;
  end

  // Look ahead at w_full_nxt so draining starts right after the marking edge.
  always_comb begin
    w_state_nxt = r_state;
    dout_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_full_nxt[r_rbank]) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        dout_valid = 1'b1;
        if (w_free) w_state_nxt = w_full_nxt[~r_rbank] ? S_DRAIN : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wcnt  <= '0;
      r_wbank <= 1'b0;
      r_drop  <= 1'b0;
      r_ovf   <= 1'b0;
      r_full  <= 2'b00;
      r_state <= S_IDLE;
      r_rbank <= 1'b0;
      r_beat  <= '0;
    end else begin
      r_full  <= w_full_nxt;
      r_state <= w_state_nxt;
      if (din_valid) r_wcnt <= r_wcnt + 1'b1;
      if (din_valid && (r_wcnt == '0)) begin
        r_drop <= w_wbank_busy;
        if (w_wbank_busy) r_ovf <= 1'b1;
      end
      if (w_mark) r_wbank <= ~r_wbank;
      if (w_accept) r_beat <= r_beat + 1'b1;
      if (w_free) r_rbank <= ~r_rbank;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int l = 0; l < LANES; l++) begin
        r_mem_re[r_wbank][{rev_lane(LW'(l)), rev_beat(r_wcnt)}] <= din_re[l*WIDTH +: WIDTH];
        r_mem_im[r_wbank][{rev_lane(LW'(l)), rev_beat(r_wcnt)}] <= din_im[l*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    dout_re = '0;
    dout_im = '0;
    if (dout_valid) begin
      for (int j = 0; j < LANES; j++) begin
        dout_re[j*WIDTH +: WIDTH] = r_mem_re[r_rbank][{r_beat, LW'(j)}];
        dout_im[j*WIDTH +: WIDTH] = r_mem_im[r_rbank][{r_beat, LW'(j)}];
      end
    end
  end

  assign dout_beat = 5'(r_beat);
  assign dout_last = dout_valid && (r_beat == LAST_BEAT);
  assign ovf_err   = r_ovf;

endmodule
`default_nettype wire

// File: doc/fft_out_reorder.md
Name: fft_out_reorder

Overview:
- Sits directly downstream of the 512-point, 16-lane FFT butterfly pipeline (Bfy_Module_0).
- Consumes its bit-reversed-order output beats (do_en / do_re / do_im) and re-emits each 512-point frame in natural bin order, 16 bins per beat.
- Uses a two-bank ping-pong buffer, so one frame can be written while the previous one drains.
- Output has a valid/ready handshake. Input has no backpressure, so overflow is detected and flagged.

Parameters:
- WIDTH, 11, bits per real/imag sample (matches FFT WIDTH_OUT).
- LANES, 16, samples per beat (fixed at 16 for this mapping).
- NPOINT, 512, points per frame; BEATS = NPOINT/LANES = 32.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rstn  in  1  asynchronous, active-low reset.
- din_valid  in  1  input beat valid; driven from FFT do_en.
- din_re  in  WIDTH*LANES  flat real bus; lane l is at [l*WIDTH +: WIDTH], signed.
- din_im  in  WIDTH*LANES  flat imag bus; same packing as din_re.
- dout_ready  in  1  downstream accepts the current beat.
- dout_valid  out  1  output beat valid.
- dout_re  out  WIDTH*LANES  natural-order real bins; lane j of beat m = bin m*16+j.
- dout_im  out  WIDTH*LANES  natural-order imag bins.
- dout_beat  out  5  index m of the current output beat (0..31).
- dout_last  out  1  high when dout_valid and dout_beat==31.
- ovf_err  out  1  sticky: an input frame was dropped.

Behaviour:
- Reset (async assert, sync release):
  - dout_valid=0, dout_beat=0, dout_last=0, ovf_err=0.
  - Both banks empty; write count=0; write bank=0; read bank=0. Memory contents are don't-care.
  - dout_re/dout_im are don't-care while dout_valid=0.
  - Reset mid-frame discards all partial and full frames.
- Input framing:
  - Every cycle with din_valid=1 is one beat. A 5-bit write counter c counts beats; 32 beats make one frame.
  - Gaps (din_valid=0) are allowed and hold c.
  - c wraps 31 -> 0.
- Address mapping:
  - Input beat c, lane l carries bin k = bitrev9(c*16+l), i.e. k = {rev4(l), rev5(c)}, 9 bits.
  - Each sample is stored at address k of the write bank. All 16 writes happen in the same cycle; the storage is a register array.
- Write control:
  - At beat c=0, the current write bank is checked.
  - If that bank is empty, the whole frame is written to it.
  - If it is still full, the whole frame is dropped: c still counts, no writes occur, the bank is not marked, ovf_err is set to 1 and stays set until reset.
  - The clock edge that captures beat 31 of an accepted frame marks the bank full and toggles the write bank.
- Read FSM (states IDLE, DRAIN):
  - IDLE -> DRAIN when the read bank is full. dout_valid rises in the first cycle after the marking edge, so latency is 1 cycle from the beat-31 edge.
  - In DRAIN: dout_valid=1; dout_re/dout_im lane j = bank[read][dout_beat*16+j]; output is combinational from the registered beat and bank.
  - Beat handshake: dout_beat advances only when dout_valid && dout_ready.
  - Data and dout_beat are held stable while dout_ready=0.
  - On acceptance of beat 31: the bank is marked empty, the read bank toggles, and dout_beat returns to 0.
  - If the other bank is already full, DRAIN continues with no bubble. Otherwise the FSM goes to IDLE and dout_valid=0 the next cycle.
- Simultaneous events:
  - A bank freed on the same edge that a new frame's beat 0 checks it counts as empty: the free takes priority, so there is no overflow.
  - Marking one bank full and freeing the other on the same edge are independent.
- Arithmetic: none; data passes through bit-exact at WIDTH bits, sign preserved.

Test Plan:
- Mapping check:
  - Stimulus: one frame with dout_ready=1; each sample's real part = its bin k, imag part = -k.
  - Required: 32 contiguous output beats starting 1 cycle after the beat-31 edge. Lane j of beat m has re = m*16+j and im = -(m*16+j).
  - Spot checks: input beat 0 lane 1 (k=256) appears at output beat 16 lane 0; input beat 1 lane 0 (k=16) appears at output beat 1 lane 0.
- Back-to-back frames:
  - Stimulus: 3 frames with din_valid held at 1 for 96 cycles; dout_ready=1.
  - Required: 96 consecutive dout_valid cycles; dout_last at beats 31, 63 and 95; ovf_err stays 0.
- Backpressure:
  - Stimulus: dout_ready toggles 1,0,1,0 during drain.
  - Required: each beat is held while ready=0; all 32 beats are delivered once, in order; dout_beat never skips.
- Overflow:
  - Stimulus: dout_ready=0 permanently; send 3 frames.
  - Required: frames 1 and 2 are stored; frame 3 is dropped and ovf_err=1 after its beat 0.
  - Then raise ready: exactly frames 1 and 2 are output (64 beats), and ovf_err stays 1.
- Input gaps:
  - Stimulus: din_valid asserted on random cycles, 32 beats spread over 80 cycles.
  - Required: output identical to the gap-free case.
- Mid-frame reset:
  - Stimulus: rstn=0 after input beat 17 of frame 1, then a clean full frame.
  - Required: all outputs are 0 immediately during reset; after release, only the clean frame is output, with correct data; ovf_err=0.
